// File: rtl/pipeline_pkg.sv
// Shared IF/ID boundary types and constants for the 5-stage RISC-V pipeline.
package pipeline_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_pkt_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// Register array for the IF/ID queue: one synchronous write port, one asynchronous read port.
module if_id_queue_mem
    import pipeline_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 2 * XLEN,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    // Storage is deliberately not reset; occupancy tracking makes stale contents invisible.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// In-order IF->ID decoupling queue with flush; define IF_ID_QUEUE_BYPASS_EN for zero-latency
// pass-through when the queue is empty.
module if_id_queue #(
    parameter int unsigned     DEPTH    = 2,
    parameter int unsigned     XLEN     = pipeline_pkg::XLEN,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(pipeline_pkg::NOP_INST)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_valid,
    input  logic [XLEN-1:0]          if_pc,
    input  logic [XLEN-1:0]          if_inst,
    output logic                     if_ready,
    output logic                     id_valid,
    output logic [XLEN-1:0]          id_pc,
    output logic [XLEN-1:0]          id_pc4,
    output logic [XLEN-1:0]          id_inst,
    input  logic                     id_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [2*XLEN-1:0] rd_data;
    logic              empty, byp, push, pop, wr_en, rd_en;

    assign empty    = (count_q == '0);
    assign if_ready = (count_q != CntW'(DEPTH));
    assign count    = count_q;

`ifdef IF_ID_QUEUE_BYPASS_EN
    assign byp = empty & if_valid & ~flush;
`else
    assign byp = 1'b0;
`endif

    always_comb begin
        push  = if_valid & if_ready & ~flush;
        pop   = id_valid & id_ready & ~flush;
        // A bypassed instruction consumed the same cycle never touches storage.
        wr_en = push & ~(byp & id_ready);
        rd_en = pop & ~byp;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count_d = count_q + 1'b1;
            end else if (rd_en && !wr_en) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        id_valid = ~empty | byp;
        id_pc    = '0;
        id_inst  = NOP_INST;
        if (!empty) begin
            id_pc   = rd_data[2*XLEN-1:XLEN];
            id_inst = rd_data[XLEN-1:0];
        end else if (byp) begin
            id_pc   = if_pc;
            id_inst = if_inst;
        end
        id_pc4 = id_pc + XLEN'(4);
    end

    if_id_queue_mem #(
        .Depth (DEPTH),
        .Width (2 * XLEN),
        .AddrW (PtrW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i ({if_pc, if_inst}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

endmodule

// File: tb/tb_if_id_queue.sv
// Randomized and directed bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;
    import pipeline_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CntW  = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_valid, if_ready, id_valid, id_ready, flush;
    logic [XLEN-1:0] if_pc, if_inst, id_pc, id_pc4, id_inst;
    logic [CntW-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_pkt_t model_q[$];

    if_id_queue #(
        .DEPTH    (DEPTH),
        .XLEN     (XLEN),
        .NOP_INST (NOP_INST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_ready (if_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_pc4   (id_pc4),
        .id_inst  (id_inst),
        .id_ready (id_ready),
        .flush    (flush),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_byp();
`ifdef IF_ID_QUEUE_BYPASS_EN
        return (model_q.size() == 0) && if_valid && !flush;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outputs(input string tag);
        logic [XLEN-1:0] e_pc, e_inst;
        bit              e_valid;
        e_valid = (model_q.size() != 0) || model_byp();
        if (model_q.size() != 0) begin
            e_pc   = model_q[0].pc;
            e_inst = model_q[0].inst;
        end else if (model_byp()) begin
            e_pc   = if_pc;
            e_inst = if_inst;
        end else begin
            e_pc   = '0;
            e_inst = NOP_INST;
        end
        check({tag, ".id_valid"}, 64'(id_valid), 64'(e_valid));
        check({tag, ".if_ready"}, 64'(if_ready), 64'(model_q.size() != DEPTH));
        check({tag, ".id_pc"},    64'(id_pc),    64'(e_pc));
        check({tag, ".id_pc4"},   64'(id_pc4),   64'(32'(e_pc + 32'd4)));
        check({tag, ".id_inst"},  64'(id_inst),  64'(e_inst));
        check({tag, ".count"},    64'(count),    64'(model_q.size()));
    endtask

    // Drive one cycle, check the combinational view, then advance the model across the edge.
    task automatic step(input string tag, input bit iv, input logic [XLEN-1:0] pc,
                        input logic [XLEN-1:0] inst, input bit ir, input bit fl);
        bit         e_valid, e_ready, byp;
        fetch_pkt_t pkt;
        if_valid = iv;
        if_pc    = pc;
        if_inst  = inst;
        id_ready = ir;
        flush    = fl;
        #3;
        check_outputs(tag);
        byp     = model_byp();
        e_valid = (model_q.size() != 0) || byp;
        e_ready = (model_q.size() != DEPTH);
        pkt.pc   = pc;
        pkt.inst = inst;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else if (!(byp && ir)) begin
            if (e_valid && ir) void'(model_q.pop_front());
            if (iv && e_ready) model_q.push_back(pkt);
        end
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        if_valid = 1'b0;
        if_pc    = '0;
        if_inst  = '0;
        id_ready = 1'b0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        check_outputs("reset");
        check("reset.inst_const", 64'(id_inst), 64'h13);
        check("reset.pc4_const", 64'(id_pc4), 64'h4);

        // Back-pressure: fill, hold third fetch, then drain in order.
        step("bp0", 1, 32'h0, 32'h1111_0001, 0, 0);
        step("bp1", 1, 32'h4, 32'h1111_0002, 0, 0);
        step("bp2", 1, 32'h8, 32'h1111_0003, 0, 0);
        check("bp.full_count", 64'(count), 64'(2));
        check("bp.full_ready", 64'(if_ready), 64'(0));
        step("bp3", 1, 32'h8, 32'h1111_0003, 1, 0);
        step("bp4", 1, 32'h8, 32'h1111_0003, 1, 0);
        check("bp.head_pc", 64'(id_pc), 64'h8);
        step("bp5", 0, 32'h0, 32'h0, 1, 0);
        step("bp6", 0, 32'h0, 32'h0, 1, 0);

        // Streaming.
        for (int i = 0; i < 10; i++) begin
            step("stream", 1, 32'h100 + 32'(4 * i), 32'h2000_0000 + 32'(i), 1, 0);
        end
        step("stream_drain", 0, 32'h0, 32'h0, 1, 0);

        // Flush while full with a concurrent fetch.
        step("fl0", 1, 32'h1f0, 32'h3000_0000, 0, 0);
        step("fl1", 1, 32'h1f4, 32'h3000_0001, 0, 0);
        step("fl2", 1, 32'h200, 32'h3000_0002, 0, 1);
        check("flush.count", 64'(count), 64'(0));
        check("flush.id_valid", 64'(id_valid), 64'(0));
        step("fl3", 1, 32'h300, 32'h3000_0003, 0, 0);
        step("fl4", 0, 32'h0, 32'h0, 1, 0);
        check("flush.next_pc", 64'(id_pc), 64'(0));

        // Asynchronous reset between edges with two entries held.
        step("ar0", 1, 32'h400, 32'h4000_0000, 0, 0);
        step("ar1", 1, 32'h404, 32'h4000_0001, 0, 0);
        if_valid = 1'b0;
        id_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        check_outputs("async_rst");
        check("async_rst.if_ready", 64'(if_ready), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("ar2", 1, 32'h500, 32'h5000_0000, 0, 0);
        step("ar3", 1, 32'h504, 32'h5000_0001, 1, 0);
        step("ar4", 0, 32'h0, 32'h0, 1, 0);
        step("ar5", 0, 32'h0, 32'h0, 1, 0);

`ifdef IF_ID_QUEUE_BYPASS_EN
        if_valid = 1'b1;
        if_pc    = 32'h40;
        if_inst  = 32'h00A0_0093;
        id_ready = 1'b1;
        flush    = 1'b0;
        #2;
        check("byp.id_valid", 64'(id_valid), 64'(1));
        check("byp.id_pc", 64'(id_pc), 64'h40);
        check("byp.id_inst", 64'(id_inst), 64'h00A0_0093);
        step("byp", 1, 32'h40, 32'h00A0_0093, 1, 0);
        check("byp.count", 64'(count), 64'(0));
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand", bit'($urandom_range(0, 1)), {$urandom_range(0, 32'h3fff_ffff), 2'b00},
                 $urandom, bit'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
